shared_ram_arbiter: RTL and testbench



---
 rtl/shared_ram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_shared_ram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arbiter.sv
// ============================================================================
// Module   : shared_ram_arbiter
// Purpose  : Round-robin arbiter and access sequencer that shares one
//            single-port, synchronous-read RAM/peripheral port between
//            NUM_REQ requesters. Each granted access takes four cycles:
//            IDLE (arbitrate) -> ACCESS (port strobed) -> CAPTURE (read
//            data returns) -> ACK (one-cycle acknowledge).
// Ports    : clk, reset        - clock, synchronous active-high reset
//            req/req_write     - per-requester request level and direction
//            req_addr/wdata    - flattened per-requester address / data
//            ack, rdata        - one-hot completion pulse, read data
//            grant_id, busy    - current/last granted index, not-idle flag
//            ram_*             - shared port (all registered outputs)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_ram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic [DATA_W-1:0]            rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         ram_enable,
  output logic                         ram_write,
  output logic                         ram_read,
  output logic [ADDR_W-1:0]            ram_address,
  output logic [DATA_W-1:0]            ram_data_in,
  input  logic [DATA_W-1:0]            ram_data_out
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               wr_q, wr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               en_q, en_d;
  logic               rw_q, rw_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;

  logic               found;
  logic [GW-1:0]      winner;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: starts one past the last grant, so the most recently
  // served requester is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last_grant_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = GW'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (found) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. Strobes and ack default low so each is
  // a single-cycle pulse in the cycle after the state that sets it.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    en_d         = 1'b0;
    rw_d         = 1'b0;
    rd_d         = 1'b0;
    addr_d       = addr_q;
    din_d        = din_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (found) begin
          last_grant_d = winner;
          grant_d      = winner;
          wr_d         = req_write[winner];
          en_d         = 1'b1;
          rw_d         = req_write[winner];
          rd_d         = ~req_write[winner];
          addr_d       = addr_arr[winner];
          din_d        = wdata_arr[winner];
        end
      end
      S_CAPTURE: begin
        if (!wr_q) rdata_d = ram_data_out;
        ack_d[grant_q] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      wr_q         <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      en_q         <= 1'b0;
      rw_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      en_q         <= en_d;
      rw_q         <= rw_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign ram_enable  = en_q;
  assign ram_write   = rw_q;
  assign ram_read    = rd_q;
  assign ram_address = addr_q;
  assign ram_data_in = din_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_ram_arbiter.sv
// ============================================================================
// Module   : tb_shared_ram_arbiter
// Purpose  : Directed self-checking bench for shared_ram_arbiter with a
//            simple synchronous-read RAM attached to the shared port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_ram_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              ram_enable;
  logic              ram_write;
  logic              ram_read;
  logic [AW-1:0]     ram_address;
  logic [DW-1:0]     ram_data_in;
  logic [DW-1:0]     ram_data_out;

  int vectors    = 0;
  int miscompares = 0;

  shared_ram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .rdata        (rdata),
    .grant_id     (grant_id),
    .busy         (busy),
    .ram_enable   (ram_enable),
    .ram_write    (ram_write),
    .ram_read     (ram_read),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read memory on the shared port
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_enable && ram_write) mem[ram_address] <= ram_data_in;
    if (ram_enable && ram_read)  ram_data_out <= mem[ram_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata);
    req[id]                  = 1'b1;
    req_write[id]            = wr;
    req_addr[id*AW +: AW]    = addr;
    req_wdata[id*DW +: DW]   = wdata;
  endtask

  // Full single-requester transaction starting in an IDLE cycle
  task automatic do_txn(input int id, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp);
    set_req(id, wr, addr, wdata);
    tick();                                  // ACCESS
    check("txn_grant", grant_id, id);
    check("txn_en", ram_enable, 1);
    check("txn_wr", ram_write, wr);
    check("txn_rd", ram_read, !wr);
    check("txn_addr", ram_address, addr);
    if (wr) check("txn_din", ram_data_in, wdata);
    check("txn_busy", busy, 1);
    check("txn_ack_access", ack, 0);
    tick();                                  // CAPTURE
    check("txn_en_off", ram_enable, 0);
    check("txn_strobes_off", {ram_write, ram_read}, 0);
    check("txn_ack_capture", ack, 0);
    tick();                                  // ACK
    check("txn_ack", ack, 32'd1 << id);
    if (!wr) check("txn_rdata", rdata, exp);
    req[id] = 1'b0;
    tick();                                  // IDLE
    check("txn_ack_clear", ack, 0);
    check("txn_idle", busy, 0);
  endtask

  initial begin
    logic [7:0] exp_rd [3];
    reset     = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {ram_enable, ram_write, ram_read}, 0);
    check("rst_addr", ram_address, 0);
    check("rst_din", ram_data_in, 0);
    reset = 1'b0;

    // Write then read through requester 0
    do_txn(0, 1'b1, 8'h10, 8'h5A, 8'h00);
    do_txn(0, 1'b0, 8'h10, 8'h00, 8'h5A);

    // Address boundary through requester 1
    do_txn(1, 1'b1, 8'hFF, 8'hA5, 8'h00);
    do_txn(1, 1'b0, 8'hFF, 8'h00, 8'hA5);

    // Preload 0x20 with 0x33 through requester 2
    do_txn(2, 1'b1, 8'h20, 8'h33, 8'h00);

    // Simultaneous requests after reset: order 0,1,2, acks 4 cycles apart
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rd[0] = 8'h5A;
    exp_rd[1] = 8'hA5;
    exp_rd[2] = 8'h33;
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b0, 8'hFF, 8'h00);
    set_req(2, 1'b0, 8'h20, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();                                // ACCESS
      check("sim_grant", grant_id, k);
      check("sim_en", ram_enable, 1);
      tick();                                // CAPTURE
      check("sim_ack_early", ack, 0);
      tick();                                // ACK
      check("sim_ack", ack, 32'd1 << k);
      check("sim_rdata", rdata, exp_rd[k]);
      req[k] = 1'b0;
      tick();                                // IDLE
      check("sim_ack_clear", ack, 0);
      check("sim_idle", busy, 0);
    end

    // Fairness: req0 and req2 held, grants alternate 0,2,0,2
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(2, 1'b0, 8'h20, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();                                // ACCESS
      check("fair_grant", grant_id, (k % 2 == 0) ? 0 : 2);
      tick();
      tick();                                // ACK
      check("fair_ack", ack, (k % 2 == 0) ? 3'b001 : 3'b100);
      check("fair_rdata", rdata, (k % 2 == 0) ? 8'h5A : 8'h33);
      if (k == 3) req = '0;
      tick();                                // IDLE
      check("fair_idle", busy, 0);
    end

    // Reset mid-operation during ACCESS of a requester-2 read
    set_req(2, 1'b0, 8'h20, 8'h00);
    tick();                                  // ACCESS
    check("rmid_grant", grant_id, 2);
    check("rmid_en", ram_enable, 1);
    reset = 1'b1;
    tick();
    check("rmid_strobes", {ram_enable, ram_write, ram_read}, 0);
    check("rmid_addr", ram_address, 0);
    check("rmid_busy", busy, 0);
    check("rmid_ack", ack, 0);
    reset = 1'b0;
    set_req(0, 1'b0, 8'h10, 8'h00);
    tick();                                  // ACCESS after release
    check("rmid_no_ack", ack, 0);
    check("rmid_regrant", grant_id, 0);
    check("rmid_en2", ram_enable, 1);
    tick();
    check("rmid_no_ack2", ack, 0);
    tick();                                  // ACK
    check("rmid_ack0", ack, 3'b001);
    check("rmid_rdata", rdata, 8'h5A);
    req = '0;
    tick();
    check("rmid_idle", busy, 0);

    // Request withdrawn during ACCESS still completes exactly once
    set_req(1, 1'b0, 8'h20, 8'h00);
    tick();                                  // ACCESS
    check("wd_grant", grant_id, 1);
    check("wd_rd", ram_read, 1);
    req[1] = 1'b0;
    tick();
    tick();                                  // ACK
    check("wd_ack", ack, 3'b010);
    check("wd_rdata", rdata, 8'h33);
    tick();                                  // IDLE
    check("wd_ack_clear", ack, 0);
    tick();
    check("wd_no_reaccess", ram_enable, 0);
    check("wd_no_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
